// File: rtl/uart_cmd_parser_if.sv
// Byte-stream input and register-write/error output bundle of uart_cmd_parser.
// master: the side feeding bytes and observing writes; slave: the parser.
interface uart_cmd_parser_if;
    logic [7:0]  data_i;
    logic        rx_done_tick_i;
    logic        we_o;
    logic [1:0]  wtype_o;
    logic [7:0]  ch_o;
    logic [31:0] wdata_o;
    logic        busy_o;
    logic        err_o;
    logic [1:0]  err_code_o;

    modport master (
        output data_i, rx_done_tick_i,
        input  we_o, wtype_o, ch_o, wdata_o, busy_o, err_o, err_code_o
    );

    modport slave (
        input  data_i, rx_done_tick_i,
        output we_o, wtype_o, ch_o, wdata_o, busy_o, err_o, err_code_o
    );
endinterface

// File: rtl/uart_cmd_parser.sv
// UART command framer: turns FREQ/PERIOD/DATA/CTRL byte frames into single-cycle
// register-write strobes, flags unknown commands, bad channels and inter-byte
// timeouts, and always falls back to IDLE so the next frame is parsed cleanly.
// Optional trailing XOR checksum byte per frame: define UART_CMD_CHECKSUM_EN.
module uart_cmd_parser #(
    parameter int unsigned OUTPUT_NUM     = 16,
    parameter logic [7:0]  CMD_FREQ       = 8'h0A,
    parameter logic [7:0]  CMD_PERIOD     = 8'h0B,
    parameter logic [7:0]  CMD_DATA       = 8'h0C,
    parameter logic [7:0]  CMD_CTRL       = 8'h0D,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic          clk_i,
    input  logic          rst_i,
    uart_cmd_parser_if.slave bus
);

    localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

    localparam logic [1:0] WT_FREQ   = 2'd0;
    localparam logic [1:0] WT_PERIOD = 2'd1;
    localparam logic [1:0] WT_DATA   = 2'd2;
    localparam logic [1:0] WT_CTRL   = 2'd3;

    localparam logic [1:0] ERR_CMD     = 2'd0;
    localparam logic [1:0] ERR_CHAN    = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

`ifdef UART_CMD_CHECKSUM_EN
    localparam logic [1:0] ERR_CSUM  = 2'd3;
    localparam logic [2:0] CK_EXTRA  = 3'd1;
`else
    localparam logic [2:0] CK_EXTRA  = 3'd0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHAN,
        S_PAYLOAD,
        S_DISCARD
`ifdef UART_CMD_CHECKSUM_EN
        , S_CHECK
`endif
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     payload_q, payload_d;
    logic [2:0]      cnt_q, cnt_d;        // bytes consumed in PAYLOAD/DISCARD
    logic [1:0]      last_q, last_d;      // index of the final payload byte (N-1)
    logic [1:0]      wtype_q, wtype_d;
    logic [7:0]      ch_q, ch_d;
    logic [TO_W-1:0] to_q, to_d;
`ifdef UART_CMD_CHECKSUM_EN
    logic [7:0]      xor_q, xor_d;
`endif

    logic            we_q, we_d;
    logic            err_q, err_d;
    logic [1:0]      err_code_q, err_code_d;
    logic [1:0]      wtype_out_q, wtype_out_d;
    logic [7:0]      ch_out_q, ch_out_d;
    logic [31:0]     wdata_out_q, wdata_out_d;
    logic            busy_q, busy_d;

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            payload_q   <= '0;
            cnt_q       <= '0;
            last_q      <= '0;
            wtype_q     <= '0;
            ch_q        <= '0;
            to_q        <= '0;
`ifdef UART_CMD_CHECKSUM_EN
            xor_q       <= '0;
`endif
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= '0;
            wtype_out_q <= '0;
            ch_out_q    <= '0;
            wdata_out_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            payload_q   <= payload_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            wtype_q     <= wtype_d;
            ch_q        <= ch_d;
            to_q        <= to_d;
`ifdef UART_CMD_CHECKSUM_EN
            xor_q       <= xor_d;
`endif
            we_q        <= we_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
            wtype_out_q <= wtype_out_d;
            ch_out_q    <= ch_out_d;
            wdata_out_q <= wdata_out_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state, frame assembly, timeout and strobe generation.
    always_comb begin
        state_d     = state_q;
        payload_d   = payload_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        wtype_d     = wtype_q;
        ch_d        = ch_q;
        to_d        = to_q;
`ifdef UART_CMD_CHECKSUM_EN
        xor_d       = xor_q;
`endif
        we_d        = 1'b0;
        err_d       = 1'b0;
        err_code_d  = err_code_q;
        wtype_out_d = wtype_out_q;
        ch_out_d    = ch_out_q;
        wdata_out_d = wdata_out_q;

        // A byte always beats the timeout when both land on the same cycle.
        if (state_q == S_IDLE || bus.rx_done_tick_i) begin
            to_d = '0;
        end else if (TO_EN && to_q == TO_LAST) begin
            state_d    = S_IDLE;
            err_d      = 1'b1;
            err_code_d = ERR_TIMEOUT;
        end else begin
            to_d = to_q + TO_W'(1);
        end

        if (bus.rx_done_tick_i) begin
`ifdef UART_CMD_CHECKSUM_EN
            xor_d = xor_q ^ bus.data_i;
`endif
            case (state_q)
                S_IDLE: begin
                    payload_d = '0;
                    cnt_d     = '0;
                    ch_d      = '0;
`ifdef UART_CMD_CHECKSUM_EN
                    xor_d     = bus.data_i;
`endif
                    case (bus.data_i)
                        CMD_FREQ:   begin wtype_d = WT_FREQ;   last_d = 2'd3; state_d = S_PAYLOAD; end
                        CMD_PERIOD: begin wtype_d = WT_PERIOD; last_d = 2'd1; state_d = S_PAYLOAD; end
                        CMD_DATA:   begin wtype_d = WT_DATA;   last_d = 2'd3; state_d = S_CHAN;    end
                        CMD_CTRL:   begin wtype_d = WT_CTRL;   last_d = 2'd0; state_d = S_CHAN;    end
                        default: begin
                            err_d      = 1'b1;
                            err_code_d = ERR_CMD;
                        end
                    endcase
                end
                S_CHAN: begin
                    ch_d = bus.data_i;
                    if (32'(bus.data_i) >= OUTPUT_NUM) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_CHAN;
                        cnt_d      = '0;
                        state_d    = S_DISCARD;
                    end else begin
                        state_d = S_PAYLOAD;
                    end
                end
                S_PAYLOAD: begin
                    payload_d[{cnt_q[1:0], 3'b000} +: 8] = bus.data_i;
                    if (cnt_q[1:0] == last_q) begin
`ifdef UART_CMD_CHECKSUM_EN
                        state_d = S_CHECK;
`else
                        state_d     = S_IDLE;
                        we_d        = 1'b1;
                        wtype_out_d = wtype_q;
                        ch_out_d    = ch_q;
                        wdata_out_d = payload_d;
`endif
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
                S_DISCARD: begin
                    // Swallow the rest of a rejected frame to stay frame-aligned.
                    if (cnt_q == {1'b0, last_q} + CK_EXTRA) begin
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
`ifdef UART_CMD_CHECKSUM_EN
                S_CHECK: begin
                    state_d = S_IDLE;
                    if (bus.data_i == xor_q) begin
                        we_d        = 1'b1;
                        wtype_out_d = wtype_q;
                        ch_out_d    = ch_q;
                        wdata_out_d = payload_q;
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = ERR_CSUM;
                    end
                end
`endif
                default: state_d = S_IDLE;
            endcase
        end

        busy_d = (state_d != S_IDLE);
    end

    assign bus.we_o       = we_q;
    assign bus.err_o      = err_q;
    assign bus.err_code_o = err_code_q;
    assign bus.wtype_o    = wtype_out_q;
    assign bus.ch_o       = ch_out_q;
    assign bus.wdata_o    = wdata_out_q;
    assign bus.busy_o     = busy_q;

endmodule

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
- Sits between the UART receiver and diff_freq_serial_out.
- Consumes the UART byte stream (data byte plus a one-cycle done tick) and frames the FREQ, PERIOD, DATA and CTRL commands.
- Emits one single-cycle register-write strobe per complete, valid frame, carrying write type, channel and a 32-bit assembled payload.
- Detects unknown commands, out-of-range channels and inter-byte timeouts, and always resynchronises to IDLE.

Parameters:
- OUTPUT_NUM, 16, number of serial output channels; valid channel range is 0..OUTPUT_NUM-1.
- CMD_FREQ, 8'h0A, command byte for a frequency-pattern update.
- CMD_PERIOD, 8'h0B, command byte for a slow/fast period update.
- CMD_DATA, 8'h0C, command byte for a channel data-pattern update.
- CMD_CTRL, 8'h0D, command byte for a channel mode/enable update.
- TIMEOUT_CYCLES, 100000, maximum clk_i cycles allowed between bytes of one frame; 0 disables the timeout.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  reset, synchronous, active-high.
- data_i  in  8  received UART byte; valid only when rx_done_tick_i is high.
- rx_done_tick_i  in  1  one-cycle byte-valid strobe.
- we_o  out  1  one-cycle write strobe.
- wtype_o  out  2  write type: 0=FREQ, 1=PERIOD, 2=DATA, 3=CTRL.
- ch_o  out  8  target channel; 0 for FREQ and PERIOD.
- wdata_o  out  32  assembled payload.
- busy_o  out  1  high whenever the FSM is not in IDLE.
- err_o  out  1  one-cycle error strobe.
- err_code_o  out  2  error code: 0=unknown cmd, 1=bad channel, 2=timeout, 3=checksum; held until the next error.

Behaviour:
- Interface: one clock (clk_i). rst_i is synchronous and active-high.
- Reset values: FSM in IDLE; all outputs 0; payload register 0; byte and timeout counters 0.
- States:
  - IDLE, CHAN, PAYLOAD, DISCARD, CHECK (CHECK exists only with the optional feature).
  - Only a byte with rx_done_tick_i=1 advances the FSM; data_i is ignored otherwise.
- IDLE:
  - On a byte, clear the payload register and byte counter.
  - FREQ -> PAYLOAD, N=4. PERIOD -> PAYLOAD, N=2. DATA -> CHAN, N=4. CTRL -> CHAN, N=1.
  - Any other byte: err_o pulse with code 0 on the next cycle; stay in IDLE.
- CHAN:
  - Latch the channel byte.
  - If the value >= OUTPUT_NUM: err_o pulse with code 1 next cycle, go to DISCARD with N bytes remaining.
  - Otherwise go to PAYLOAD.
- PAYLOAD:
  - Payload byte k (0-based) is written to wdata bits [8k+7:8k], LSB first.
  - Unfilled upper bits stay 0. PERIOD gives slow in [7:0] and fast in [15:8]. CTRL gives the ctrl byte in [7:0] (bit1=mode, bit0=en).
- Commit:
  - On the cycle after the Nth payload byte, drive we_o=1 for exactly one cycle with wtype_o, ch_o and wdata_o valid.
  - FSM returns to IDLE in that same cycle.
  - wtype_o, ch_o and wdata_o hold their values until the next commit.
  - Latency from the final rx_done_tick_i to we_o is one cycle.
- DISCARD: count down the remaining N bytes with no write, then return to IDLE. This keeps the parser aligned to frame boundaries.
- Timeout:
  - The counter runs in every non-IDLE state and resets on each byte.
  - On reaching TIMEOUT_CYCLES: go to IDLE, err_o pulse with code 2, partial frame dropped.
  - If a byte and the timeout threshold coincide, the byte wins and no timeout fires.
- Back-to-back: a byte arriving in the commit cycle is processed from IDLE. No bytes are lost at any rate the UART can deliver.
- rst_i asserted mid-frame: the frame is dropped, no we_o is issued, and all state returns to reset values.
- we_o and err_o are never asserted in the same cycle.

Optional Feature:
- Macro: UART_CMD_CHECKSUM_EN.
- Defined:
  - Every frame carries one extra trailing byte, handled in the CHECK state.
  - That byte must equal the XOR of all preceding frame bytes, including the command byte.
  - Match: commit one cycle after the checksum byte.
  - Mismatch: err_o pulse with code 3, no we_o.
  - Frames discarded for a bad channel also consume their checksum byte.
- Undefined: the CHECK state and XOR accumulator are absent; frames have no checksum byte; code 3 is never produced.

Test Plan:
- FREQ bytes 0A 55 55 55 55 -> one we_o pulse, wtype=0, ch=0, wdata=32'h55555555, one cycle after the last tick.
- PERIOD bytes 0B 14 05 -> we_o pulse, wtype=1, wdata=32'h00000514.
- DATA ch 3: bytes 0C 03 78 56 34 12 -> we_o pulse, wtype=2, ch=3, wdata=32'h12345678. Then CTRL bytes 0D 03 03 -> wtype=3, ch=3, wdata=32'h00000003.
- CTRL with ch 16: bytes 0D 10 01 -> err_o pulse, code=1, no we_o. A following FREQ frame commits correctly.
- Unknown byte FF -> err code 0. Separately, send 0A 11 22 and stall for TIMEOUT_CYCLES -> err code 2, busy_o falls. A new FREQ frame then commits.
- rst_i pulsed after 0C 05 55 -> no we_o, busy_o=0. A full DATA frame afterwards commits normally.
